// File: rtl/rst_sequencer.sv
// Staged reset release: async assert, synchronized in-order release after a hold period.
// Optional watchdog on ext_ready (macro RST_SEQ_WDOG_EN) raises fault and parks in FAULT.
module rst_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 4,
   parameter int HOLD_CYCLES = 25,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 16,
   parameter int WDOG_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ext_ready,
   input  logic               soft_rst_req,
   output logic [NUM_OUT-1:0] rst_out,
   output logic               seq_done,
   output logic               fault
);

   localparam int IDX_W = $clog2(NUM_OUT + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_ALL   = IDX_W'(NUM_OUT);

   typedef enum logic [2:0] {
      S_RESET, S_WAIT_READY, S_HOLD, S_RELEASE, S_RUN, S_FAULT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
   logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
   logic               seq_done_q, seq_done_d;
   logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
   logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
   logic               rst_sync, rdy_sync, active;

   always_comb begin
      rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b0};
      rdy_sync_d = {rdy_sync_q[SYNC_STAGES-2:0], ext_ready};
   end

   assign rst_sync = rst_sync_q[SYNC_STAGES-1];
   assign rdy_sync = rdy_sync_q[SYNC_STAGES-1];
   assign idx_inc  = idx_q + IDX_W'(1);
   assign active   = (state_q == S_HOLD) || (state_q == S_RELEASE) || (state_q == S_RUN);

   // idx counts how many outputs have been released so far
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (rst_sync) begin
         state_d = S_RESET;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (active && !rdy_sync) begin
         state_d = S_WAIT_READY;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (active && soft_rst_req) begin
         state_d = S_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_RESET: begin
               state_d = S_WAIT_READY;
               cnt_d   = '0;
               idx_d   = '0;
            end
            S_WAIT_READY: begin
               if (rdy_sync) begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
               end
`ifdef RST_SEQ_WDOG_EN
               else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
                  state_d = S_FAULT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  idx_d   = IDX_W'(1);
                  state_d = (NUM_OUT == 1) ? S_RUN : S_RELEASE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  idx_d = idx_inc;
                  if (idx_inc == IDX_ALL) state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN:   state_d = S_RUN;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RESET;
         endcase
      end
   end

   // Outputs are registered from the next state so they change on the transition edge
   always_comb begin
      rst_out_d  = '1;
      seq_done_d = 1'b0;
      case (state_d)
         S_RELEASE: begin
            for (int k = 0; k < NUM_OUT; k++) rst_out_d[k] = (k >= int'(idx_d));
         end
         S_RUN: begin
            rst_out_d  = '0;
            seq_done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_sync_q <= '1;
         rdy_sync_q <= '0;
         state_q    <= S_RESET;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_out_q  <= '1;
         seq_done_q <= 1'b0;
      end else begin
         rst_sync_q <= rst_sync_d;
         rdy_sync_q <= rdy_sync_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_out_q  <= rst_out_d;
         seq_done_q <= seq_done_d;
      end
   end

`ifdef RST_SEQ_WDOG_EN
   logic fault_q, fault_d;
   assign fault_d = (state_d == S_FAULT);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign rst_out  = rst_out_q;
   assign seq_done = seq_done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: expected output transitions are queued with their edge delay.
module tb_rst_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ext_ready = 1'b1;
   logic       soft_rst_req = 1'b0;
   logic [3:0] rst_out;
   logic       seq_done;
   logic       fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         dly;
      logic [5:0] val;
   } exp_t;

   exp_t       sb[$];
   logic [5:0] prev;

   always #4 clk = ~clk;

   rst_sequencer #(
      .SYNC_STAGES(2), .NUM_OUT(4), .HOLD_CYCLES(25), .STAGE_GAP(8),
      .CNT_W(16), .WDOG_CYCLES(50)
   ) dut (
      .clk(clk), .rst(rst), .ext_ready(ext_ready), .soft_rst_req(soft_rst_req),
      .rst_out(rst_out), .seq_done(seq_done), .fault(fault)
   );

   function automatic logic [5:0] obs();
      return {rst_out, seq_done, fault};
   endfunction

   task automatic push(input string tag, input int dly, input logic [5:0] val);
      exp_t e;
      e.tag = tag;
      e.dly = dly;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic push_seq(input string tag, input int first);
      push({tag, "_b0"}, first, 6'b1110_0_0);
      push({tag, "_b1"}, 8, 6'b1100_0_0);
      push({tag, "_b2"}, 8, 6'b1000_0_0);
      push({tag, "_done"}, 8, 6'b0000_1_0);
   endtask

   // Pops each expectation and waits (bounded) for the next output change
   task automatic drain();
      exp_t       e;
      int         n;
      logic [5:0] cur;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         do begin
            @(negedge clk);
            n++;
            cur = obs();
         end while (cur === prev && n < e.dly + 10);
         checks++;
         assert (cur === e.val && n == e.dly) else begin
            errors++;
            $error("FAIL %s: got %b after %0d edges, expected %b after %0d edges",
                   e.tag, cur, n, e.val, e.dly);
         end
         prev = cur;
      end
   endtask

   task automatic check_now(input string tag, input logic [5:0] val);
      checks++;
      assert (obs() === val) else begin
         errors++;
         $error("FAIL %s: got %b, expected %b", tag, obs(), val);
      end
   endtask

   task automatic steady(input string tag, input int cycles, input logic [5:0] val);
      logic stable;
      stable = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (obs() !== prev) stable = 1'b0;
      end
      checks++;
      assert (stable === 1'b1 && obs() === val) else begin
         errors++;
         $error("FAIL %s: stable=%b got %b, expected steady %b", tag, stable, obs(), val);
      end
      prev = obs();
   endtask

   task automatic soft_pulse();
      fork
         begin
            soft_rst_req = 1'b1;
            @(negedge clk);
            soft_rst_req = 1'b0;
         end
      join_none
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_now("reset_state", 6'b1111_0_0);
      repeat (22) @(negedge clk);

      // power-on: 2 sync + 1 RESET->WAIT + 1 WAIT->HOLD, then 25 hold cycles
      rst  = 1'b0;
      prev = obs();
      push_seq("por", 29);
      drain();

      soft_pulse();
      push("soft_assert", 1, 6'b1111_0_0);
      push_seq("soft", 25);
      drain();

      soft_pulse();
      push("soft2_assert", 1, 6'b1111_0_0);
      push("soft2_b0", 25, 6'b1110_0_0);
      push("soft2_b1", 8, 6'b1100_0_0);
      drain();
      ext_ready = 1'b0;
      push("loss_assert", 3, 6'b1111_0_0);
      drain();
      steady("loss_wait", 40, 6'b1111_0_0);
      ext_ready = 1'b1;
      push_seq("rearm", 28);
      drain();

      // one-cycle ext_ready dip coinciding with soft_rst_req at the FSM
      fork
         begin
            ext_ready = 1'b0;
            @(negedge clk);
            ext_ready = 1'b1;
            @(negedge clk);
            soft_rst_req = 1'b1;
            @(negedge clk);
            soft_rst_req = 1'b0;
         end
      join_none
      push("race_assert", 3, 6'b1111_0_0);
      push_seq("race", 26);
      drain();

      soft_pulse();
      push("hold_assert", 1, 6'b1111_0_0);
      drain();
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_now("async_hold", 6'b1111_0_0);
      @(negedge clk);
      rst  = 1'b0;
      prev = obs();
      push_seq("post_hold", 29);
      drain();

      soft_pulse();
      push("rel_assert", 1, 6'b1111_0_0);
      push("rel_b0", 25, 6'b1110_0_0);
      push("rel_b1", 8, 6'b1100_0_0);
      drain();
      #2 rst = 1'b1;
      #1 check_now("async_release", 6'b1111_0_0);
      @(negedge clk);
      rst  = 1'b0;
      prev = obs();
      push_seq("post_release", 29);
      drain();

`ifdef RST_SEQ_WDOG_EN
      @(negedge clk);
      rst       = 1'b1;
      ext_ready = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      prev = obs();
      push("wdog_fault", 53, 6'b1111_0_1);
      drain();
      ext_ready = 1'b1;
      steady("wdog_late_ready", 40, 6'b1111_0_1);
      #2 rst = 1'b1;
      #1 check_now("wdog_clear", 6'b1111_0_0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset consumer for the design top level. Accepts the board or bench reset and an external ready signal (e.g. PLL lock).
- Produces NUM_OUT staged, active-high reset outputs, one per downstream domain.
- All outputs assert asynchronously. They release synchronously, one at a time, in index order, after a hold period.
- A sequence-complete flag is raised when the last output releases.

Parameters:
- SYNC_STAGES, 2: flop depth of the reset-deassert synchronizer and of the ext_ready synchronizer (min 2).
- NUM_OUT, 4: number of staged reset outputs (min 1).
- HOLD_CYCLES, 25: cycles spent in HOLD before the first release (200 ns at 125 MHz); min 1.
- STAGE_GAP, 8: cycles between consecutive output releases; min 1.
- CNT_W, 16: width of the internal cycle counter; must hold max(HOLD_CYCLES, STAGE_GAP, WDOG_CYCLES).
- WDOG_CYCLES, 1000: watchdog limit for WAIT_READY; used only with RST_SEQ_WDOG_EN.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  asynchronous, active-high reset.
- ext_ready  input  1  asynchronous ready/lock; passed through SYNC_STAGES flops internally.
- soft_rst_req  input  1  synchronous, single-cycle soft reset request.
- rst_out  output  NUM_OUT  staged active-high resets; bit 0 releases first.
- seq_done  output  1  high while all rst_out bits are released.
- fault  output  1  watchdog timeout flag.

Behaviour:
- rst asserted (async) forces:
  - rst_out = all ones, seq_done = 0, fault = 0;
  - state = RESET; counter = 0; stage index = 0;
  - both synchronizer chains cleared.
- rst release: internal rst_sync deasserts after SYNC_STAGES rising edges. On the next edge, RESET -> WAIT_READY.
- WAIT_READY:
  - rst_out stays all ones.
  - When ext_ready_sync = 1, go to HOLD with counter = 0.
- HOLD:
  - Counter increments each cycle.
  - On the HOLD_CYCLES-th edge after entry, go to RELEASE. The same edge clears rst_out[0] and resets the counter.
- RELEASE:
  - Each STAGE_GAP-th edge clears the next rst_out bit, in ascending index order.
  - The edge that clears rst_out[NUM_OUT-1] also sets seq_done = 1 and moves to RUN.
  - NUM_OUT = 1: HOLD goes directly to RUN and sets seq_done on the same edge that clears bit 0.
- RUN: rst_out = 0, seq_done = 1. Holds until an event below.
- ext_ready_sync falling in HOLD, RELEASE or RUN:
  - Next edge sets rst_out = all ones and seq_done = 0.
  - State goes to WAIT_READY; counter and index cleared.
- soft_rst_req = 1 in HOLD, RELEASE or RUN:
  - Next edge sets rst_out = all ones and seq_done = 0.
  - State goes to HOLD with counter = 0 (full restart of the hold period).
- soft_rst_req in RESET or WAIT_READY: ignored.
- ext_ready loss and soft_rst_req in the same cycle: ext_ready loss wins (WAIT_READY).
- rst asserted mid-sequence: immediate async return to the reset values above, regardless of state.
- Invariant: rst_out is always thermometer-coded. A released bit k implies all bits < k are released.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- Defined:
  - The counter runs in WAIT_READY.
  - If ext_ready_sync is still 0 after WDOG_CYCLES cycles, enter FAULT and set fault = 1.
  - FAULT holds rst_out = all ones and seq_done = 0. Only rst exits FAULT.
  - A late ext_ready in FAULT is ignored.
- Undefined:
  - No FAULT state; WAIT_READY waits indefinitely.
  - fault is tied to 0 and WDOG_CYCLES is unused.

Test Plan:
- Defaults, 125 MHz clock, ext_ready high, rst high for 200 ns then low. Required:
  - HOLD entered 4 edges after rst falls.
  - rst_out[0] falls 25 cycles after HOLD entry.
  - rst_out[1], [2], [3] fall at +8, +16 and +24 cycles after rst_out[0].
  - seq_done rises with rst_out[3].
- In RUN, 1-cycle soft_rst_req. Required: next edge rst_out = 4'b1111 and seq_done = 0; rst_out[0] falls 25 cycles later.
- In RELEASE after rst_out = 4'b1100, drop ext_ready. Required: rst_out = 4'b1111 within SYNC_STAGES+1 edges; state WAIT_READY. Re-raise ext_ready: the full 25/8 sequence repeats.
- ext_ready drop and soft_rst_req in the same cycle. Required: WAIT_READY reached, not HOLD.
- Assert rst mid-HOLD and mid-RELEASE. Required: rst_out = 4'b1111 with no clock edge (async); seq_done = 0.
- With RST_SEQ_WDOG_EN and WDOG_CYCLES = 50, ext_ready held low. Required:
  - fault = 1 after 50 cycles in WAIT_READY.
  - Raising ext_ready afterwards leaves rst_out = 4'b1111.
  - A pulse on rst clears fault.
